// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N:1 data mux with round-robin arbitration, valid/ready on all
// channels and a single-entry registered output stage.
// Optional packet lock: define MUX_RR_LOCK_EN to add in_last and hold the
// grant on one channel until its end-of-packet beat transfers.
module mux_rr_arb #(
    parameter int Data_Width = 8,
    parameter int Num_Inputs = 4,
    parameter int Sel_Width  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [Num_Inputs*Data_Width-1:0] in_data,
    input  logic [Num_Inputs-1:0]            in_valid,
`ifdef MUX_RR_LOCK_EN
    input  logic [Num_Inputs-1:0]            in_last,
`endif
    output logic [Num_Inputs-1:0]            in_ready,
    output logic [Data_Width-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [Sel_Width-1:0]             out_sel
);

    logic [Sel_Width-1:0]  last_grant;
    logic [Sel_Width-1:0]  win;
    logic                  found;
    logic                  slot_free;
    logic                  xfer;
    logic [Data_Width-1:0] win_data;

`ifdef MUX_RR_LOCK_EN
    logic                  locked;
    logic [Sel_Width-1:0]  lock_ch;
`endif

    assign slot_free = !out_valid || out_ready;

    // Pick the first valid channel after last_grant (or the locked channel).
    always_comb begin
        logic [Sel_Width-1:0] cidx;
        found = 1'b0;
        win   = '0;
        cidx  = '0;
        for (int k = 1; k <= Num_Inputs; k++) begin
            cidx = Sel_Width'((int'(last_grant) + k) % Num_Inputs);
            if (!found && in_valid[cidx]) begin
                found = 1'b1;
                win   = cidx;
            end
        end
`ifdef MUX_RR_LOCK_EN
        // A packet in flight owns the output even while its channel idles.
        if (locked) begin
            found = in_valid[lock_ch];
            win   = lock_ch;
        end
`endif
    end

    assign xfer = found && slot_free;

    // Grant is one-hot to the winner only when the output slot can take it.
    always_comb begin
        in_ready = '0;
        if (xfer && !rst)
            in_ready[win] = 1'b1;
    end

    // Select the winning channel's word.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < Num_Inputs; i++)
            if (win == Sel_Width'(i))
                win_data = in_data[i*Data_Width +: Data_Width];
    end

    // Output register: load on transfer, clear valid on drain, hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            last_grant <= Sel_Width'(Num_Inputs - 1);
`ifdef MUX_RR_LOCK_EN
            locked     <= 1'b0;
            lock_ch    <= '0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= win;
`ifdef MUX_RR_LOCK_EN
            // Priority only rotates once the whole packet has gone.
            locked  <= !in_last[win];
            lock_ch <= win;
            if (in_last[win])
                last_grant <= win;
`else
            last_grant <= win;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb: directed and randomized checks of mux_rr_arb against a
// cycle-level reference model of the arbitration rules.
module tb_mux_rr_arb;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]  in_valid = '0;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_sel;
`ifdef MUX_RR_LOCK_EN
    logic [N-1:0]  in_last = '1;
`endif

    always #5 clk = ~clk;

    mux_rr_arb #(.Data_Width(W), .Num_Inputs(N), .Sel_Width(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
`ifdef MUX_RR_LOCK_EN
        .in_last  (in_last),
`endif
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sel  (out_sel)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int            m_last;
    bit            m_ov;
    logic [W-1:0]  m_data;
    logic [SW-1:0] m_sel;
    bit            m_lock;
    int            m_lch;
    logic [N-1:0]  obs_rdy, exp_rdy;

    task automatic model_reset();
        m_last = N - 1; m_ov = 0; m_data = '0; m_sel = '0; m_lock = 0; m_lch = 0;
    endtask

    // Who should be granted this cycle, from the rules alone.
    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r = '0;
        int order[$];
        if (rst) return '0;
        if (m_ov && !out_ready) return '0;
        if (m_lock) order.push_back(m_lch);
        else for (int k = 1; k <= N; k++) order.push_back((m_last + k) % N);
        foreach (order[j])
            if (in_valid[order[j]]) begin
                r[order[j]] = 1'b1;
                return r;
            end
        return r;
    endfunction

    task automatic model_clk(input logic [N-1:0] g);
        int c = -1;
        for (int i = 0; i < N; i++) if (g[i]) c = i;
        if (c >= 0) begin
            m_ov = 1; m_data = in_data[c*W +: W]; m_sel = SW'(c);
`ifdef MUX_RR_LOCK_EN
            if (in_last[c]) begin m_lock = 0; m_last = c; end
            else begin m_lock = 1; m_lch = c; end
`else
            m_last = c;
`endif
        end else if (out_ready) begin
            m_ov = 0;
        end
    endtask

    // One clock: sample grant before the edge, advance model, settle after edge.
    task automatic tick();
        @(negedge clk);
        obs_rdy = in_ready;
        exp_rdy = exp_ready();
        model_clk(exp_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(8'h10 + i);
    endtask

    task automatic test_reset();
        model_reset();
        in_valid = '1;
        #2;
        n_cmp++; if (in_ready !== '0) begin n_err++; $display("FAIL rst_ready_held got %b want 0000", in_ready); end
        in_valid = '0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready got %b want 0000", in_ready); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_data got %h want 00", out_data); end
        n_cmp++; if (out_sel !== 2'd0) begin n_err++; $display("FAIL rst_sel got %0d want 0", out_sel); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        in_valid = 4'b0100; in_data[2*W +: W] = 8'hA5; out_ready = 1'b1;
        tick();
        in_valid = '0;
        n_cmp++; if (obs_rdy !== 4'b0100) begin n_err++; $display("FAIL single_ready got %b want 0100", obs_rdy); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_data got %h want a5", out_data); end
        n_cmp++; if (out_sel !== 2'd2) begin n_err++; $display("FAIL single_sel got %0d want 2", out_sel); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_drain_data got %h want a5", out_data); end
    endtask

    task automatic test_fairness();
        do_reset();
        set_ramp(); in_valid = '1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_sel !== SW'(i % N) || out_data !== W'(8'h10 + i % N)) begin
                n_err++; $display("FAIL fair_beat%0d got v=%b sel=%0d d=%h want v=1 sel=%0d d=%h",
                                  i, out_valid, out_sel, out_data, i % N, 8'h10 + i % N);
            end
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_ramp(); in_valid = 4'b1010; out_ready = 1'b0;
        tick();
        n_cmp++; if (out_sel !== 2'd1 || out_data !== 8'h11) begin n_err++; $display("FAIL bp_first got sel=%0d d=%h want sel=1 d=11", out_sel, out_data); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (obs_rdy !== 4'b0000) begin n_err++; $display("FAIL bp_ready%0d got %b want 0000", i, obs_rdy); end
            n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h11) begin
                n_err++; $display("FAIL bp_hold%0d got v=%b sel=%0d d=%h want v=1 sel=1 d=11", i, out_valid, out_sel, out_data);
            end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_sel !== 2'd3 || out_data !== 8'h13) begin n_err++; $display("FAIL bp_rel1 got sel=%0d d=%h want sel=3 d=13", out_sel, out_data); end
        tick();
        n_cmp++; if (out_sel !== 2'd1 || out_data !== 8'h11) begin n_err++; $display("FAIL bp_rel2 got sel=%0d d=%h want sel=1 d=11", out_sel, out_data); end
        in_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_ramp(); in_valid = 4'b0110; out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre got %b want 1", out_valid); end
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000) begin
            n_err++; $display("FAIL rmid_async got v=%b d=%h rdy=%b want v=0 d=00 rdy=0000", out_valid, out_data, in_ready);
        end
        in_valid = '1; out_ready = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        tick();
        n_cmp++; if (out_sel !== 2'd0 || out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_first got sel=%0d v=%b want sel=0 v=1", out_sel, out_valid); end
        in_valid = '0;
        tick();
    endtask

`ifdef MUX_RR_LOCK_EN
    task automatic test_lock();
        logic [N-1:0] vseq [5] = '{4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0011};
        logic [N-1:0] lseq [5] = '{4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1111};
        int           sseq [5] = '{0, -1, 0, 0, 1};
        do_reset();
        set_ramp(); out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = vseq[i]; in_last = lseq[i];
            tick();
            if (sseq[i] < 0) begin
                n_cmp++; if (obs_rdy !== 4'b0000 || out_valid !== 1'b0) begin
                    n_err++; $display("FAIL lock_gap got rdy=%b v=%b want rdy=0000 v=0", obs_rdy, out_valid);
                end
            end else begin
                n_cmp++; if (out_valid !== 1'b1 || out_sel !== SW'(sseq[i])) begin
                    n_err++; $display("FAIL lock_beat%0d got v=%b sel=%0d want v=1 sel=%0d", i, out_valid, out_sel, sseq[i]);
                end
            end
        end
        in_valid = '0; in_last = '1;
        tick();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_data   = {$urandom, $urandom};
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_RR_LOCK_EN
            in_last   = N'($urandom);
`endif
            tick();
            n_cmp++; if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL rnd_ready cyc%0d got %b want %b", i, obs_rdy, exp_rdy); end
            n_cmp++; if (out_valid !== m_ov) begin n_err++; $display("FAIL rnd_valid cyc%0d got %b want %b", i, out_valid, m_ov); end
            n_cmp++; if (out_data !== m_data) begin n_err++; $display("FAIL rnd_data cyc%0d got %h want %h", i, out_data, m_data); end
            n_cmp++; if (out_sel !== m_sel) begin n_err++; $display("FAIL rnd_sel cyc%0d got %0d want %0d", i, out_sel, m_sel); end
        end
        in_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid();
`ifdef MUX_RR_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
